multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Moore-style main control sequencer for the multicycle RISC-V core.
- Steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK phases.
- Drives the 3-bit ALU_Op consumed by the ALU control decoder, plus all datapath enables and multiplexer selects.
- Sits between the instruction register's opcode field and the shared ALU, unified memory port, register file and PC.

Parameters:
- INSTRET_WIDTH, 32, width of the retired-instruction counter; used only when PERF_CNT_EN is defined.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- opcode_i  in  7  IR[6:0]; stable from DECODE onward.
- zero_i  in  1  ALU branch-condition flag; 1 means the branch is taken.
- mem_ready_i  in  1  memory completion for the current read or write request.
- PC_Write_o  out  1  PC load enable.
- IR_Write_o  out  1  IR load enable; the datapath also latches old_PC on this strobe.
- Mem_Read_o  out  1  memory read request.
- Mem_Write_o  out  1  memory write request.
- Reg_Write_o  out  1  register file write enable.
- ALU_Src_A_o  out  2  00 = rs1, 01 = old_PC, 10 = zero.
- ALU_Src_B_o  out  1  0 = rs2, 1 = immediate.
- Result_Src_o  out  2  00 = ALUOut register, 01 = memory data register, 10 = old_PC+4.
- PC_Src_o  out  2  00 = PC+4, 01 = old_PC+imm (dedicated adder), 10 = ALU result with bit0 cleared.
- ALU_Op_o  out  3  000 R, 001 I-arith, 010 LUI, 011 AUIPC, 100 LW/SW, 101 branch, 110 JAL, 111 JALR.
- illegal_o  out  1  one-cycle pulse on an unsupported opcode.
- state_o  out  3  current state, for debug.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM_RD=3, MEM_WR=4, WB_MEM=5, WB_ALU=6.
- Reset: while reset=0 the state is FETCH and every enable, illegal_o and ALU_Op_o are 0.
  - Reset is asynchronous and aborts any state, including an outstanding memory request.
  - After release, the first rising edge evaluates FETCH.
- Defaults: all enables are 0, all selects are 00/0 and ALU_Op_o=000 unless listed below.
- FETCH:
  - Mem_Read_o=1, PC_Src_o=00.
  - If mem_ready_i=1: IR_Write_o=1 and PC_Write_o=1 in the same cycle, next state DECODE.
  - Otherwise stay in FETCH with both enables 0 (unbounded wait).
- DECODE: one cycle, no enables; next state EXEC when opcode_i is legal.
  - Illegal opcode: illegal_o=1 for this cycle, next state FETCH, no architectural update.
- EXEC, by opcode (ALU_Op_o is always driven per the table above):
  - 0110011: SrcA=00, SrcB=0, next WB_ALU.
  - 0010011: SrcA=00, SrcB=1, next WB_ALU.
  - 0110111: SrcA=10, SrcB=1, next WB_ALU.
  - 0010111: SrcA=01, SrcB=1, next WB_ALU.
  - 0000011: SrcA=00, SrcB=1, next MEM_RD.
  - 0100011: SrcA=00, SrcB=1, next MEM_WR.
  - 1100011: SrcA=00, SrcB=0; PC_Src=01; PC_Write_o=zero_i (combinational); next FETCH.
  - 1101111: PC_Src=01, PC_Write=1, Reg_Write=1, Result_Src=10; next FETCH.
  - 1100111: SrcA=00, SrcB=1, PC_Src=10, PC_Write=1, Reg_Write=1, Result_Src=10; next FETCH.
- MEM_RD: Mem_Read_o=1 held until mem_ready_i; on ready, next WB_MEM.
- MEM_WR: Mem_Write_o=1 held until mem_ready_i; on ready, next FETCH.
- WB_MEM: Reg_Write=1, Result_Src=01; next FETCH.
- WB_ALU: Reg_Write=1, Result_Src=00; next FETCH.
- Latency with zero wait states, from FETCH to the next FETCH:
  - 4 cycles: R, I, LUI, AUIPC, SW.
  - 5 cycles: LW.
  - 3 cycles: branch, JAL, JALR.
  - Each memory wait cycle adds 1.
- Output timing:
  - Enables are combinational from state, except IR_Write_o/PC_Write_o in FETCH (gated by mem_ready_i) and PC_Write_o in branch EXEC (gated by zero_i).
  - No enable may glitch high during reset.
  - Mem_Read_o and Mem_Write_o are never asserted together.
- opcode_i is ignored in FETCH, MEM_RD, MEM_WR and the WB states.

Optional Feature:
- Macro PERF_CNT_EN.
- Defined:
  - Adds output instret_o [INSTRET_WIDTH-1:0].
  - Cleared by reset.
  - Increments by 1 on every transition into FETCH from EXEC, MEM_WR, WB_MEM or WB_ALU; it does not increment on the illegal path.
  - Wraps modulo 2^INSTRET_WIDTH.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- R-type add, opcode 0110011, mem_ready_i tied 1:
  - States 0→1→2→6→0.
  - ALU_Op_o=000 in EXEC.
  - Reg_Write_o=1 only in cycle 4, with Result_Src_o=00.
- LW, opcode 0000011, mem_ready_i low for 2 cycles in MEM_RD:
  - Mem_Read_o stays 1 for 3 cycles.
  - WB_MEM then asserts Reg_Write_o=1 with Result_Src_o=01.
  - Total 7 cycles.
- BEQ, opcode 1100011, ALU_Op_o=101:
  - zero_i=1: PC_Write_o=1 with PC_Src_o=01.
  - Repeat with zero_i=0: PC_Write_o stays 0.
  - Either way, back in FETCH after 3 cycles.
- JALR, opcode 1100111:
  - EXEC shows PC_Src_o=10, Reg_Write_o=1, Result_Src_o=10, ALU_Op_o=111.
  - JAL, opcode 1101111: PC_Src_o=01, ALU_Op_o=110.
- Illegal opcode 1111111: illegal_o pulses exactly 1 cycle in DECODE, no write enable fires, next state FETCH.
- Reset asserted mid-MEM_WR with Mem_Write_o=1:
  - Mem_Write_o drops immediately, without waiting for a clock edge.
  - state_o=0 while reset=0.
  - With PERF_CNT_EN defined, instret_o=0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Moore control sequencer for the multicycle RISC-V core (FETCH/DECODE/EXEC/MEM/WB).
// Optional retired-instruction counter instret_o enabled by defining PERF_CNT_EN.
module multicycle_control_fsm
`ifdef PERF_CNT_EN
  #(parameter int unsigned INSTRET_WIDTH = 32)
`endif
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       PC_Write_o,
  output logic       IR_Write_o,
  output logic       Mem_Read_o,
  output logic       Mem_Write_o,
  output logic       Reg_Write_o,
  output logic [1:0] ALU_Src_A_o,
  output logic       ALU_Src_B_o,
  output logic [1:0] Result_Src_o,
  output logic [1:0] PC_Src_o,
  output logic [2:0] ALU_Op_o,
  output logic       illegal_o,
  output logic [2:0] state_o
`ifdef PERF_CNT_EN
  , output logic [INSTRET_WIDTH-1:0] instret_o
`endif
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM_RD = 3'd3,
    MEM_WR = 3'd4,
    WB_MEM = 3'd5,
    WB_ALU = 3'd6
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  state_t state_q, state_d;
  logic   legal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  assign state_o = state_q;

  // Everything below is gated by reset so no enable can rise while the core is held.
  always_comb begin
    state_d      = state_q;
    legal        = 1'b0;
    PC_Write_o   = 1'b0;
    IR_Write_o   = 1'b0;
    Mem_Read_o   = 1'b0;
    Mem_Write_o  = 1'b0;
    Reg_Write_o  = 1'b0;
    ALU_Src_A_o  = '0;
    ALU_Src_B_o  = 1'b0;
    Result_Src_o = '0;
    PC_Src_o     = '0;
    ALU_Op_o     = '0;
    illegal_o    = 1'b0;
    if (reset) begin
      unique case (state_q)
        FETCH: begin
          Mem_Read_o = 1'b1;
          if (mem_ready_i) begin
            IR_Write_o = 1'b1;
            PC_Write_o = 1'b1;
            state_d    = DECODE;
          end
        end
        DECODE: begin
          legal = opcode_i inside {OP_R, OP_I, OP_LUI, OP_AUIPC, OP_LW, OP_SW,
                                   OP_BR, OP_JAL, OP_JALR};
          if (legal) begin
            state_d = EXEC;
          end else begin
            illegal_o = 1'b1;
            state_d   = FETCH;
          end
        end
        EXEC: begin
          state_d = FETCH;
          unique case (opcode_i)
            OP_R:     begin ALU_Op_o = 3'b000; state_d = WB_ALU; end
            OP_I:     begin ALU_Op_o = 3'b001; ALU_Src_B_o = 1'b1; state_d = WB_ALU; end
            OP_LUI:   begin ALU_Op_o = 3'b010; ALU_Src_A_o = 2'b10; ALU_Src_B_o = 1'b1; state_d = WB_ALU; end
            OP_AUIPC: begin ALU_Op_o = 3'b011; ALU_Src_A_o = 2'b01; ALU_Src_B_o = 1'b1; state_d = WB_ALU; end
            OP_LW:    begin ALU_Op_o = 3'b100; ALU_Src_B_o = 1'b1; state_d = MEM_RD; end
            OP_SW:    begin ALU_Op_o = 3'b100; ALU_Src_B_o = 1'b1; state_d = MEM_WR; end
            OP_BR: begin
              ALU_Op_o   = 3'b101;
              PC_Src_o   = 2'b01;
              PC_Write_o = zero_i;
            end
            OP_JAL: begin
              ALU_Op_o     = 3'b110;
              PC_Src_o     = 2'b01;
              PC_Write_o   = 1'b1;
              Reg_Write_o  = 1'b1;
              Result_Src_o = 2'b10;
            end
            OP_JALR: begin
              ALU_Op_o     = 3'b111;
              ALU_Src_B_o  = 1'b1;
              PC_Src_o     = 2'b10;
              PC_Write_o   = 1'b1;
              Reg_Write_o  = 1'b1;
              Result_Src_o = 2'b10;
            end
            default: ;
          endcase
        end
        MEM_RD: begin
          Mem_Read_o = 1'b1;
          if (mem_ready_i) state_d = WB_MEM;
        end
        MEM_WR: begin
          Mem_Write_o = 1'b1;
          if (mem_ready_i) state_d = FETCH;
        end
        WB_MEM: begin
          Reg_Write_o  = 1'b1;
          Result_Src_o = 2'b01;
          state_d      = FETCH;
        end
        WB_ALU: begin
          Reg_Write_o = 1'b1;
          state_d     = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic                     retire;
  logic [INSTRET_WIDTH-1:0] instret_q;

  // DECODE->FETCH (illegal) is deliberately excluded from the source set.
  assign retire = (state_d == FETCH) &&
                  (state_q inside {EXEC, MEM_WR, WB_MEM, WB_ALU});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      instret_q <= '0;
    else if (retire) instret_q <= instret_q + INSTRET_WIDTH'(1);
  end

  assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: per-cycle stimulus and expected outputs are
// queued, then replayed one clock at a time; PERF_CNT_EN adds instret_o checks.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] opcode_i = '0;
  logic       zero_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic       PC_Write_o, IR_Write_o, Mem_Read_o, Mem_Write_o, Reg_Write_o;
  logic [1:0] ALU_Src_A_o, Result_Src_o, PC_Src_o;
  logic       ALU_Src_B_o, illegal_o;
  logic [2:0] ALU_Op_o, state_o;
`ifdef PERF_CNT_EN
  logic [31:0] instret_o;
  int unsigned exp_instret = 0;
`endif

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  multicycle_control_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .opcode_i     (opcode_i),
    .zero_i       (zero_i),
    .mem_ready_i  (mem_ready_i),
    .PC_Write_o   (PC_Write_o),
    .IR_Write_o   (IR_Write_o),
    .Mem_Read_o   (Mem_Read_o),
    .Mem_Write_o  (Mem_Write_o),
    .Reg_Write_o  (Reg_Write_o),
    .ALU_Src_A_o  (ALU_Src_A_o),
    .ALU_Src_B_o  (ALU_Src_B_o),
    .Result_Src_o (Result_Src_o),
    .PC_Src_o     (PC_Src_o),
    .ALU_Op_o     (ALU_Op_o),
    .illegal_o    (illegal_o),
    .state_o      (state_o)
`ifdef PERF_CNT_EN
    , .instret_o  (instret_o)
`endif
  );

  always #5 clk = ~clk;

  // {state, pcw, irw, mrd, mwr, rw, srcA, srcB, resSrc, pcSrc, aluop, illegal}
  logic [18:0] obs;
  assign obs = {state_o, PC_Write_o, IR_Write_o, Mem_Read_o, Mem_Write_o, Reg_Write_o,
                ALU_Src_A_o, ALU_Src_B_o, Result_Src_o, PC_Src_o, ALU_Op_o, illegal_o};

  function automatic logic [18:0] ev(logic [2:0] st, logic pcw, logic irw, logic mr, logic mw,
                                     logic rw, logic [1:0] sa, logic sb, logic [1:0] rs,
                                     logic [1:0] ps, logic [2:0] op, logic ill);
    return {st, pcw, irw, mr, mw, rw, sa, sb, rs, ps, op, ill};
  endfunction

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic        z;
    logic        rdy;
    logic [18:0] exp;
  } item_t;

  item_t sb[$];

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_LW = 7'b0000011, OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic [18:0] V_ZERO, V_FGO, V_FWAIT, V_DEC, V_WBALU;

  task automatic push(string n, logic [6:0] op, logic z, logic rdy, logic [18:0] x);
    item_t e;
    e.name = n; e.op = op; e.z = z; e.rdy = rdy; e.exp = x;
    sb.push_back(e);
  endtask

  task automatic note_retire();
`ifdef PERF_CNT_EN
    exp_instret++;
`endif
  endtask

  // Leading FETCH (ready) + DECODE cycles common to every legal instruction.
  task automatic push_front_end(string n, logic [6:0] op);
    push({n, "_fetch"}, op, 1'b0, 1'b1, V_FGO);
    push({n, "_decode"}, op, 1'b0, 1'b1, V_DEC);
  endtask

  task automatic test_reset();
    opcode_i = OP_R; mem_ready_i = 1'b1; reset = 1'b0;
    #2;
    total_cnt++;
    if (obs !== V_ZERO) $display("FAIL reset_async: got %b expected %b", obs, V_ZERO);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (obs !== V_ZERO) $display("FAIL reset_held: got %b expected %b", obs, V_ZERO);
    else pass_cnt++;
`ifdef PERF_CNT_EN
    total_cnt++;
    if (instret_o !== 32'd0) $display("FAIL reset_instret: got %0d expected 0", instret_o);
    else pass_cnt++;
`endif
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_alu_ops();
    push_front_end("r", OP_R);
    push("r_exec", OP_R, 1'b0, 1'b1, ev(3'd2, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 0));
    push("r_wb", OP_R, 1'b0, 1'b1, V_WBALU);
    push_front_end("i", OP_I);
    push("i_exec", OP_I, 1'b0, 1'b1, ev(3'd2, 0,0,0,0,0, 2'b00, 1, 2'b00, 2'b00, 3'b001, 0));
    push("i_wb", OP_I, 1'b0, 1'b1, V_WBALU);
    push_front_end("lui", OP_LUI);
    push("lui_exec", OP_LUI, 1'b0, 1'b1, ev(3'd2, 0,0,0,0,0, 2'b10, 1, 2'b00, 2'b00, 3'b010, 0));
    push("lui_wb", OP_LUI, 1'b0, 1'b1, V_WBALU);
    push_front_end("auipc", OP_AUIPC);
    push("auipc_exec", OP_AUIPC, 1'b0, 1'b1, ev(3'd2, 0,0,0,0,0, 2'b01, 1, 2'b00, 2'b00, 3'b011, 0));
    push("auipc_wb", OP_AUIPC, 1'b0, 1'b1, V_WBALU);
    repeat (4) note_retire();
    while (sb.size() > 0) begin
      item_t e = sb.pop_front();
      opcode_i = e.op; zero_i = e.z; mem_ready_i = e.rdy;
      @(negedge clk);
      total_cnt++;
      if (obs !== e.exp) $display("FAIL %s: got %b expected %b", e.name, obs, e.exp);
      else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_store();
    push("fetch_wait0", OP_LW, 1'b0, 1'b0, V_FWAIT);
    push("fetch_wait1", OP_LW, 1'b0, 1'b0, V_FWAIT);
    push_front_end("lw", OP_LW);
    push("lw_exec", OP_LW, 1'b0, 1'b1, ev(3'd2, 0,0,0,0,0, 2'b00, 1, 2'b00, 2'b00, 3'b100, 0));
    push("lw_mem_wait0", OP_LW, 1'b0, 1'b0, ev(3'd3, 0,0,1,0,0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 0));
    push("lw_mem_wait1", OP_LW, 1'b0, 1'b0, ev(3'd3, 0,0,1,0,0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 0));
    push("lw_mem_done", OP_LW, 1'b0, 1'b1, ev(3'd3, 0,0,1,0,0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 0));
    push("lw_wb", OP_LW, 1'b0, 1'b1, ev(3'd5, 0,0,0,0,1, 2'b00, 0, 2'b01, 2'b00, 3'b000, 0));
    push_front_end("sw", OP_SW);
    push("sw_exec", OP_SW, 1'b0, 1'b1, ev(3'd2, 0,0,0,0,0, 2'b00, 1, 2'b00, 2'b00, 3'b100, 0));
    push("sw_mem", OP_SW, 1'b0, 1'b1, ev(3'd4, 0,0,0,1,0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 0));
    repeat (2) note_retire();
    while (sb.size() > 0) begin
      item_t e = sb.pop_front();
      opcode_i = e.op; zero_i = e.z; mem_ready_i = e.rdy;
      @(negedge clk);
      total_cnt++;
      if (obs !== e.exp) $display("FAIL %s: got %b expected %b", e.name, obs, e.exp);
      else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    push_front_end("beq_t", OP_BR);
    push("beq_taken", OP_BR, 1'b1, 1'b1, ev(3'd2, 1,0,0,0,0, 2'b00, 0, 2'b00, 2'b01, 3'b101, 0));
    push_front_end("beq_nt", OP_BR);
    push("beq_not_taken", OP_BR, 1'b0, 1'b1, ev(3'd2, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b01, 3'b101, 0));
    repeat (2) note_retire();
    while (sb.size() > 0) begin
      item_t e = sb.pop_front();
      opcode_i = e.op; zero_i = e.z; mem_ready_i = e.rdy;
      @(negedge clk);
      total_cnt++;
      if (obs !== e.exp) $display("FAIL %s: got %b expected %b", e.name, obs, e.exp);
      else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jumps();
    push_front_end("jal", OP_JAL);
    push("jal_exec", OP_JAL, 1'b0, 1'b1, ev(3'd2, 1,0,0,0,1, 2'b00, 0, 2'b10, 2'b01, 3'b110, 0));
    push_front_end("jalr", OP_JALR);
    push("jalr_exec", OP_JALR, 1'b0, 1'b1, ev(3'd2, 1,0,0,0,1, 2'b00, 1, 2'b10, 2'b10, 3'b111, 0));
    repeat (2) note_retire();
    while (sb.size() > 0) begin
      item_t e = sb.pop_front();
      opcode_i = e.op; zero_i = e.z; mem_ready_i = e.rdy;
      @(negedge clk);
      total_cnt++;
      if (obs !== e.exp) $display("FAIL %s: got %b expected %b", e.name, obs, e.exp);
      else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    push("ill_fetch", OP_BAD, 1'b1, 1'b1, V_FGO);
    push("ill_decode", OP_BAD, 1'b1, 1'b1, ev(3'd1, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 1));
    push("ill_back_fetch", OP_BAD, 1'b1, 1'b0, V_FWAIT);
    while (sb.size() > 0) begin
      item_t e = sb.pop_front();
      opcode_i = e.op; zero_i = e.z; mem_ready_i = e.rdy;
      @(negedge clk);
      total_cnt++;
      if (obs !== e.exp) $display("FAIL %s: got %b expected %b", e.name, obs, e.exp);
      else pass_cnt++;
      @(posedge clk); #1;
    end
`ifdef PERF_CNT_EN
    total_cnt++;
    if (instret_o !== exp_instret) $display("FAIL instret_count: got %0d expected %0d", instret_o, exp_instret);
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid_write();
    logic [18:0] mw_exp;
    mw_exp = ev(3'd4, 0,0,0,1,0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 0);
    push_front_end("sw_rst", OP_SW);
    push("sw_rst_exec", OP_SW, 1'b0, 1'b1, ev(3'd2, 0,0,0,0,0, 2'b00, 1, 2'b00, 2'b00, 3'b100, 0));
    push("sw_rst_mem", OP_SW, 1'b0, 1'b0, mw_exp);
    while (sb.size() > 0) begin
      item_t e = sb.pop_front();
      opcode_i = e.op; zero_i = e.z; mem_ready_i = e.rdy;
      @(negedge clk);
      total_cnt++;
      if (obs !== e.exp) $display("FAIL %s: got %b expected %b", e.name, obs, e.exp);
      else pass_cnt++;
      if (sb.size() > 0) begin
        @(posedge clk); #1;
      end
    end
    #1 reset = 1'b0;
    #1;
    total_cnt++;
    if (obs !== V_ZERO) $display("FAIL rst_mid_write_async: got %b expected %b", obs, V_ZERO);
    else pass_cnt++;
`ifdef PERF_CNT_EN
    exp_instret = 0;
    total_cnt++;
    if (instret_o !== 32'd0) $display("FAIL rst_mid_write_instret: got %0d expected 0", instret_o);
    else pass_cnt++;
`endif
    @(posedge clk); #1;
    total_cnt++;
    if (obs !== V_ZERO) $display("FAIL rst_mid_write_held: got %b expected %b", obs, V_ZERO);
    else pass_cnt++;
    reset = 1'b1;
  endtask

  task automatic test_back_to_back();
    push_front_end("b2b_r", OP_R);
    push("b2b_r_exec", OP_R, 1'b0, 1'b1, ev(3'd2, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 0));
    push("b2b_r_wb", OP_R, 1'b0, 1'b1, V_WBALU);
    push_front_end("b2b_jal", OP_JAL);
    push("b2b_jal_exec", OP_JAL, 1'b0, 1'b1, ev(3'd2, 1,0,0,0,1, 2'b00, 0, 2'b10, 2'b01, 3'b110, 0));
    push("b2b_final_fetch", OP_R, 1'b0, 1'b0, V_FWAIT);
    repeat (2) note_retire();
    while (sb.size() > 0) begin
      item_t e = sb.pop_front();
      opcode_i = e.op; zero_i = e.z; mem_ready_i = e.rdy;
      @(negedge clk);
      total_cnt++;
      if (obs !== e.exp) $display("FAIL %s: got %b expected %b", e.name, obs, e.exp);
      else pass_cnt++;
      @(posedge clk); #1;
    end
`ifdef PERF_CNT_EN
    total_cnt++;
    if (instret_o !== exp_instret) $display("FAIL instret_after_reset: got %0d expected %0d", instret_o, exp_instret);
    else pass_cnt++;
`endif
  endtask

  initial begin
    V_ZERO  = '0;
    V_FGO   = ev(3'd0, 1,1,1,0,0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 0);
    V_FWAIT = ev(3'd0, 0,0,1,0,0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 0);
    V_DEC   = ev(3'd1, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 0);
    V_WBALU = ev(3'd6, 0,0,0,0,1, 2'b00, 0, 2'b00, 2'b00, 3'b000, 0);
    test_reset();
    test_alu_ops();
    test_load_store();
    test_branch();
    test_jumps();
    test_illegal();
    test_reset_mid_write();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
